// File: rtl/output_writer_ctrl_if.sv
// Output-writer controller bus: datapath word stream in, file-writer strobes out.
// slave = controller side, master = the block that drives start/abort and the words.
interface output_writer_ctrl_if;
    logic        start;
    logic        abort;
    logic        in_valid;
    logic [24:0] in_data;
    logic        in_ready;
    logic        load_next_file;
    logic        write;
    logic [24:0] data_out;
    logic [9:0]  index;
    logic        busy;
    logic        file_done;
    logic        done;

    modport slave (
        input  start, abort, in_valid, in_data,
        output in_ready, load_next_file, write, data_out, index, busy, file_done, done
    );

    modport master (
        output start, abort, in_valid, in_data,
        input  in_ready, load_next_file, write, data_out, index, busy, file_done, done
    );
endinterface

// File: rtl/output_writer_ctrl.sv
// Output writer controller: sequences NUM_FILES files of WORDS_PER_FILE words each,
// opening a file, streaming accepted datapath words to the writer one cycle later,
// closing the file and signalling the end of the run.
module output_writer_ctrl #(
    parameter int NUM_FILES      = 4,
    parameter int WORDS_PER_FILE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    output_writer_ctrl_if.slave  bus
);
    localparam int              CNT_W     = (WORDS_PER_FILE > 1) ? $clog2(WORDS_PER_FILE) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_FILE - 1);
    localparam logic [9:0]      LAST_FILE = 10'(NUM_FILES - 1);

    typedef enum logic [2:0] {IDLE, LOAD, STREAM, CLOSE, FIN} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] word_cnt;
    logic [9:0]       file_idx;
    logic             accept;
    logic             write_q;
    logic [24:0]      data_q;
    logic             in_ready_c, load_c, file_done_c, done_c, busy_c;

    // A word moves only while streaming; the handshake is independent of abort so a
    // word taken on the abort cycle is still owed to the writer.
    assign accept = (state == STREAM) && bus.in_valid;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and state-decoded outputs; abort overrides every non-idle transition.
    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        load_c      = 1'b0;
        file_done_c = 1'b0;
        done_c      = 1'b0;
        busy_c      = (state != IDLE);
        case (state)
            IDLE:   if (bus.start) state_nxt = LOAD;
            LOAD: begin
                load_c    = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                in_ready_c = 1'b1;
                if (accept && (word_cnt == LAST_WORD)) state_nxt = CLOSE;
            end
            CLOSE: begin
                file_done_c = 1'b1;
                state_nxt   = (file_idx == LAST_FILE) ? FIN : LOAD;
            end
            FIN: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.abort && (state != IDLE)) state_nxt = IDLE;
    end

    // Word counter: cleared when a file opens, bumped per accepted word.
    always_ff @(posedge clk) begin
        if (rst)                 word_cnt <= '0;
        else if (state == LOAD)  word_cnt <= '0;
        else if (accept)         word_cnt <= word_cnt + 1'b1;
    end

    // File index: cleared on start, advanced on close unless this was the last file;
    // it holds its final value after the run (and after an abort).
    always_ff @(posedge clk) begin
        if (rst)
            file_idx <= '0;
        else if ((state == IDLE) && bus.start)
            file_idx <= '0;
        else if ((state == CLOSE) && !bus.abort && (file_idx != LAST_FILE))
            file_idx <= file_idx + 10'd1;
    end

    // One-cycle registered write path; reset drops any owed write, data holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            data_q  <= '0;
        end else begin
            write_q <= accept;
            if (accept) data_q <= bus.in_data;
        end
    end

    assign bus.in_ready       = in_ready_c;
    assign bus.load_next_file = load_c;
    assign bus.file_done      = file_done_c;
    assign bus.done           = done_c;
    assign bus.busy           = busy_c;
    assign bus.write          = write_q;
    assign bus.data_out       = data_q;
    assign bus.index          = file_idx;
endmodule

// File: doc/output_writer_ctrl.md
OUTPUT_WRITER_CTRL -- requirements
Module: output_writer_ctrl

Interface
REQ-001 SHALL have parameter NUM_FILES, default 4: number of output files per run, range 1..1024.
REQ-002 SHALL have parameter WORDS_PER_FILE, default 16: words written per file, range 1..65536.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit: begin a run; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: cancel the current run.
REQ-007 SHALL have port in_valid, input, 1 bit: datapath word available.
REQ-008 SHALL have port in_data, input, 25 bits: datapath result word.
REQ-009 SHALL have port in_ready, output, 1 bit: controller accepts a word this cycle.
REQ-010 SHALL have port load_next_file, output, 1 bit: one-cycle pulse to the file writer to open the file for index.
REQ-011 SHALL have port write, output, 1 bit: write strobe to the file writer.
REQ-012 SHALL have port data_out, output, 25 bits: word qualified by write.
REQ-013 SHALL have port index, output, 10 bits: current file index.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port file_done, output, 1 bit: one-cycle pulse after the last word of a file.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a run.

Function
REQ-017 SHALL implement an FSM with states IDLE, LOAD, STREAM, CLOSE and FIN.
REQ-018 IDLE: start=1 SHALL clear index to 0 and go to LOAD; start=0 SHALL keep the FSM in IDLE.
REQ-019 LOAD: load_next_file SHALL be 1 for exactly this cycle, the word counter SHALL clear to 0, and the next state SHALL be STREAM.
REQ-020 STREAM: in_ready SHALL be 1; in_ready SHALL be 0 in all other states.
REQ-021 A word SHALL be accepted when in_valid and in_ready are both 1; in_valid=0 in STREAM SHALL hold state and counter with no write.
REQ-022 For each accepted word, write SHALL be 1 and data_out SHALL equal that word on the next cycle (1-cycle registered latency).
REQ-023 write SHALL be 0 on every cycle not covered by REQ-022.
REQ-024 data_out SHALL hold its last value when write is 0.
REQ-025 The word counter SHALL increment per accepted word; acceptance at count WORDS_PER_FILE-1 SHALL move the FSM to CLOSE.
REQ-026 CLOSE: file_done SHALL be 1 for exactly this cycle; this cycle coincides with the write of the last word.
REQ-027 CLOSE with index=NUM_FILES-1 SHALL go to FIN; otherwise index SHALL increment by 1 and the FSM SHALL go to LOAD.
REQ-028 FIN: done SHALL be 1 for exactly this cycle, then the FSM SHALL go to IDLE; index SHALL hold its final value.
REQ-029 start SHALL be ignored outside IDLE, including in FIN.
REQ-030 abort=1 SHALL move any non-IDLE state to IDLE on the next cycle with no further load_next_file, file_done or done.
REQ-031 A write already owed for a word accepted on the abort cycle SHALL still be issued.
REQ-032 If rst and abort are asserted together, rst SHALL take priority.
REQ-033 With WORDS_PER_FILE=1, each file SHALL take LOAD, one STREAM accept, then CLOSE.
REQ-034 Minimum run length SHALL be NUM_FILES*(WORDS_PER_FILE+2)+2 cycles from start to done.

Reset
REQ-035 rst=1 SHALL force IDLE and clear the word counter.
REQ-036 rst=1 SHALL drive index=0, data_out=0, and in_ready, load_next_file, write, busy, file_done and done to 0 on the next edge.
REQ-037 rst asserted mid-run SHALL discard any pending write.

Verification
REQ-038 Defaults, start pulse at cycle 0, in_valid held 1 with in_data = 0..63 -> load_next_file at cycles 1, 19, 37, 55; 64 writes in order; file_done at cycles 18, 36, 54, 72; done at cycle 73; index ends at 3.
REQ-039 in_valid toggled 1,0 every cycle during file 0 -> writes spaced 2 cycles apart with data unchanged; no write on idle cycles; file_done only after the 16th accept.
REQ-040 abort asserted on the 5th STREAM accept of file 2 -> that word is still written; the FSM is in IDLE the next cycle; no later load_next_file or done; busy is 0.
REQ-041 rst asserted in STREAM with a write pending -> all outputs 0 on the next cycle and no write; a subsequent start restarts at index 0.
REQ-042 NUM_FILES=1, WORDS_PER_FILE=1, in_data=25'h1ABCDEF -> one load_next_file, one write with data_out=25'h1ABCDEF coincident with file_done, then done.
REQ-043 start held 1 throughout a run -> no restart before done; a new run begins from IDLE the cycle after FIN.
